// File: rtl/pokey_pkg.sv
// Shared POKEY definitions used by the serial output transmitter.
// Holds the SEROUT state encoding, line idle level and counter sizing helper.
package pokey_pkg;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } serout_state_t;

    localparam logic SER_IDLE_LEVEL = 1'b1;

    // Bit counter must hold 0..data_bits-1 and never collapse to zero width.
    function automatic int ser_cnt_width(input int data_bits);
        return (data_bits < 2) ? 1 : $clog2(data_bits);
    endfunction

    localparam int SER_CNT_W_DEFAULT = ser_cnt_width(8);

endpackage

// File: rtl/pokey_serout.sv
// POKEY serial output (SOD) transmitter: double-buffered holding/shift registers,
// start + LSB-first data + stop framing, paced by an external bit_tick.
module pokey_serout
    import pokey_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_tick,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 force_break,
    output logic                 sod,
    output logic                 need_data,
    output logic                 need_data_pulse,
    output logic                 done,
    output logic                 busy
);

    localparam int               CNT_W    = ser_cnt_width(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

    serout_state_t        state, state_next;
    logic                 line_reg, line_next;
    logic                 hold_full, hold_full_next;
    logic [DATA_BITS-1:0] hold_reg, hold_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 pulse_next;
    logic                 transfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= SER_IDLE;
            line_reg        <= SER_IDLE_LEVEL;
            hold_full       <= 1'b0;
            hold_reg        <= '0;
            shift_reg       <= '0;
            cnt             <= '0;
            need_data_pulse <= 1'b0;
        end else begin
            state           <= state_next;
            line_reg        <= line_next;
            hold_full       <= hold_full_next;
            hold_reg        <= hold_next;
            shift_reg       <= shift_next;
            cnt             <= cnt_next;
            need_data_pulse <= pulse_next;
        end
    end

    // The shifter moves right one place per data bit, so bit 0 is always the next bit out.
    always_comb begin
        state_next     = state;
        line_next      = line_reg;
        hold_full_next = hold_full;
        hold_next      = hold_reg;
        shift_next     = shift_reg;
        cnt_next       = cnt;
        pulse_next     = 1'b0;
        transfer       = 1'b0;

        if (bit_tick) begin
            unique case (state)
                SER_IDLE, SER_STOP: begin
                    if (hold_full) begin
                        transfer = 1'b1;
                    end else begin
                        state_next = SER_IDLE;
                        line_next  = SER_IDLE_LEVEL;
                    end
                end
                SER_START: begin
                    line_next  = shift_reg[0];
                    cnt_next   = '0;
                    state_next = SER_DATA;
                end
                SER_DATA: begin
                    if (cnt == CNT_LAST) begin
                        line_next  = SER_IDLE_LEVEL;
                        state_next = SER_STOP;
                    end else begin
                        shift_next = shift_reg >> 1;
                        line_next  = shift_next[0];
                        cnt_next   = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = SER_IDLE;
                    line_next  = SER_IDLE_LEVEL;
                end
            endcase
        end

        if (transfer) begin
            shift_next     = hold_reg;
            hold_full_next = 1'b0;
            line_next      = 1'b0;
            state_next     = SER_START;
            pulse_next     = 1'b1;
        end

        // A write in the transfer cycle lands after the shifter has taken the old byte.
        if (wr_en) begin
            hold_next      = wr_data;
            hold_full_next = 1'b1;
        end
    end

    assign sod       = line_reg & ~force_break;
    assign need_data = ~hold_full;
    assign done      = (state == SER_IDLE) && !hold_full;
    assign busy      = (state != SER_IDLE);

endmodule

// File: tb/tb_pokey_serout.sv
// Self-checking bench for pokey_serout: a frame-position reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pokey_serout;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         bit_tick = 1'b0;
    logic         wr_en = 1'b0;
    logic [N-1:0] wr_data = '0;
    logic         force_break = 1'b0;
    logic         sod, need_data, need_data_pulse, done, busy;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    pokey_serout #(.DATA_BITS(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .bit_tick        (bit_tick),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .force_break     (force_break),
        .sod             (sod),
        .need_data       (need_data),
        .need_data_pulse (need_data_pulse),
        .done            (done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Reference model: position within the frame (-1 idle, 0 start, 1..N data, N+1 stop).
    int           m_pos   = -1;
    logic [N-1:0] m_frame = '0;
    logic [N-1:0] m_hold  = '0;
    bit           m_full  = 1'b0;
    bit           m_pulse = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pos   = -1;
            m_full  = 1'b0;
            m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (bit_tick) begin
                if (m_pos == -1 || m_pos == N + 1) begin
                    if (m_full) begin
                        m_frame = m_hold;
                        m_full  = 1'b0;
                        m_pos   = 0;
                        m_pulse = 1'b1;
                    end else begin
                        m_pos = -1;
                    end
                end else begin
                    m_pos = m_pos + 1;
                end
            end
            if (wr_en) begin
                m_hold = wr_data;
                m_full = 1'b1;
            end
        end
    end

    function automatic logic model_line();
        if (m_pos == -1)     return 1'b1;
        else if (m_pos == 0) return 1'b0;
        else if (m_pos <= N) return m_frame[m_pos-1];
        else                 return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_sod",   16'(sod),             16'(model_line() & ~force_break));
            checkOutput("model_need",  16'(need_data),       16'(!m_full));
            checkOutput("model_done",  16'(done),            16'(m_pos == -1 && !m_full));
            checkOutput("model_busy",  16'(busy),            16'(m_pos != -1));
            checkOutput("model_pulse", 16'(need_data_pulse), 16'(m_pulse));
        end
    end

    // Drive inputs for exactly one clock edge, then release the strobes 2ns after it.
    task automatic applyStimulus(input logic tick, input logic wr, input logic [N-1:0] data);
        bit_tick = tick;
        wr_en    = wr;
        wr_data  = data;
        @(posedge clk);
        #2;
        bit_tick = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        reset = 1'b0;
    endtask

    // One tick followed by gap-1 quiet cycles; sod is sampled right after the tick edge.
    task automatic tickSample(input int gap, output logic bitval);
        applyStimulus(1'b1, 1'b0, '0);
        bitval = sod;
        idleCycles(gap - 1);
    endtask

    task automatic runFrame(input int gap, output logic [N+1:0] bits);
        for (int i = 0; i < N + 2; i++) begin
            tickSample(gap, bits[i]);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        logic [N+1:0] bits;
        logic         b;

        #2;
        doReset();
        check_en = 1'b1;
        checkOutput("reset_sod",   16'(sod),             16'h1);
        checkOutput("reset_need",  16'(need_data),       16'h1);
        checkOutput("reset_done",  16'(done),            16'h1);
        checkOutput("reset_busy",  16'(busy),            16'h0);
        checkOutput("reset_pulse", 16'(need_data_pulse), 16'h0);

        // Scenario: 0xA5 with 16-cycle bit spacing.
        applyStimulus(1'b0, 1'b1, 8'hA5);
        checkOutput("a5_need_after_wr", 16'(need_data), 16'h0);
        idleCycles(3);
        checkOutput("a5_not_started", 16'(sod), 16'h1);
        applyStimulus(1'b1, 1'b0, '0);
        bits[0] = sod;
        checkOutput("a5_pulse_tick1", 16'(need_data_pulse), 16'h1);
        idleCycles(1);
        checkOutput("a5_pulse_gone", 16'(need_data_pulse), 16'h0);
        idleCycles(14);
        for (int i = 1; i < N + 2; i++) tickSample(16, bits[i]);
        checkOutput("a5_frame", 16'(bits), 16'(10'b1101001010));
        checkOutput("a5_done_in_stop", 16'(done), 16'h0);
        tickSample(16, b);
        checkOutput("a5_done_end", 16'(done), 16'h1);
        checkOutput("a5_busy_end", 16'(busy), 16'h0);

        // Scenario: 0x3C, then 0xC3 written during data bit 3 -> back-to-back frames.
        applyStimulus(1'b0, 1'b1, 8'h3C);
        idleCycles(2);
        for (int i = 0; i < 5; i++) tickSample(4, bits[i]);
        applyStimulus(1'b0, 1'b1, 8'hC3);
        checkOutput("bb_need_low", 16'(need_data), 16'h0);
        for (int i = 5; i < N + 2; i++) tickSample(4, bits[i]);
        checkOutput("bb_frame1", 16'(bits), 16'({1'b1, 8'h3C, 1'b0}));
        checkOutput("bb_need_in_stop", 16'(need_data), 16'h0);
        runFrame(4, bits);
        checkOutput("bb_frame2", 16'(bits), 16'({1'b1, 8'hC3, 1'b0}));
        tickSample(4, b);
        checkOutput("bb_done", 16'(done), 16'h1);

        // Scenario: two writes while holding is empty mid-frame; only the last survives.
        applyStimulus(1'b0, 1'b1, 8'h77);
        tickSample(4, b);
        applyStimulus(1'b0, 1'b1, 8'h11);
        applyStimulus(1'b0, 1'b1, 8'h22);
        for (int i = 1; i < N + 2; i++) tickSample(4, b);
        runFrame(4, bits);
        checkOutput("ovw_frame", 16'(bits), 16'({1'b1, 8'h22, 1'b0}));
        tickSample(4, b);
        checkOutput("ovw_done", 16'(done), 16'h1);

        // Scenario: write coinciding with the STOP-state transfer tick.
        applyStimulus(1'b0, 1'b1, 8'h96);
        tickSample(4, b);
        applyStimulus(1'b0, 1'b1, 8'h4B);
        for (int i = 1; i < N + 2; i++) tickSample(4, b);
        applyStimulus(1'b1, 1'b1, 8'hE7);
        bits[0] = sod;
        checkOutput("stopwr_pulse", 16'(need_data_pulse), 16'h1);
        checkOutput("stopwr_need",  16'(need_data),       16'h0);
        idleCycles(1);
        checkOutput("stopwr_pulse_1cyc", 16'(need_data_pulse), 16'h0);
        idleCycles(2);
        for (int i = 1; i < N + 2; i++) tickSample(4, bits[i]);
        checkOutput("stopwr_old_byte", 16'(bits), 16'({1'b1, 8'h4B, 1'b0}));
        runFrame(4, bits);
        checkOutput("stopwr_new_byte", 16'(bits), 16'({1'b1, 8'hE7, 1'b0}));
        tickSample(4, b);

        // Scenario: break held across a 0xFF frame; timing must be unchanged.
        force_break = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'hFF);
        runFrame(4, bits);
        checkOutput("brk_line_low", 16'(bits), 16'h0);
        checkOutput("brk_busy_stop", 16'(busy), 16'h1);
        tickSample(4, b);
        checkOutput("brk_done", 16'(done), 16'h1);
        checkOutput("brk_sod_idle", 16'(sod), 16'h0);
        force_break = 1'b0;
        idleCycles(1);
        checkOutput("brk_release", 16'(sod), 16'h1);

        // Scenario: reset during data bit 4 with a byte pending in holding.
        applyStimulus(1'b0, 1'b1, 8'h0F);
        for (int i = 0; i < 6; i++) tickSample(4, bits[i]);
        applyStimulus(1'b0, 1'b1, 8'h99);
        checkOutput("rst_mid_busy_before", 16'(busy), 16'h1);
        doReset();
        checkOutput("rst_mid_sod",  16'(sod),       16'h1);
        checkOutput("rst_mid_busy", 16'(busy),      16'h0);
        checkOutput("rst_mid_need", 16'(need_data), 16'h1);
        checkOutput("rst_mid_done", 16'(done),      16'h1);
        tickSample(4, b);
        checkOutput("rst_hold_discarded", 16'(busy), 16'h0);
        applyStimulus(1'b0, 1'b1, 8'h5A);
        runFrame(4, bits);
        checkOutput("rst_5a_frame", 16'(bits), 16'({1'b1, 8'h5A, 1'b0}));
        tickSample(4, b);
        checkOutput("rst_5a_done", 16'(done), 16'h1);

        idleCycles(3);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
